exp_mask_unpack: RTL and testbench

- Streaming ExpandMask sampler for ML-DSA: accepts packed SHAKE256 squeeze words, unpacks gamma1-width fields and emits NUM_LANES coefficients per beat of (gamma1 - a) mod q.
- gamma1 is runtime selectable per polynomial: 2^17 (18-bit fields) or 2^19 (20-bit fields).
- Sits between the Keccak squeeze interface and the NTT/memory write path.
- Processes exactly one 256-coefficient polynomial per start.

---
 rtl/exp_mask_unpack.sv | 168 ++++++++++++++++
 tb/tb_exp_mask_unpack.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_mask_unpack.sv
// ExpandMask unpacker: turns packed SHAKE256 squeeze words into NUM_LANES
// coefficients per beat of (gamma1 - a) mod q, with gamma1 = 2^17 or 2^19
// chosen per polynomial.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_i; counters hold their last values
// RUN    | accepting words, unpacking beats until the last beat is taken
// DONE   | single cycle, done_o high, then back to IDLE
module exp_mask_unpack #(
  parameter int IN_W      = 64,
  parameter int NUM_LANES = 4,
  parameter int COEFF_W   = 23,
  parameter int NUM_COEFF = 256,
  parameter int BUF_W     = 160
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         zeroize,
  input  logic                         start_i,
  input  logic                         gamma1_sel_i,
  input  logic                         data_valid_i,
  input  logic [IN_W-1:0]              data_i,
  output logic                         data_ready_o,
  output logic                         coeff_valid_o,
  output logic [NUM_LANES*COEFF_W-1:0] coeff_o,
  input  logic                         coeff_ready_i,
  output logic                         done_o
);

  localparam int NUM_BEATS = NUM_COEFF / NUM_LANES;
  localparam int TAKE18    = NUM_LANES * 18;
  localparam int TAKE20    = NUM_LANES * 20;
  localparam int WORDS18   = NUM_COEFF * 18 / IN_W;
  localparam int WORDS20   = NUM_COEFF * 20 / IN_W;
  localparam int CNT_W     = $clog2(BUF_W + 1);
  localparam int WCNT_W    = $clog2(WORDS20 + 1);
  localparam int BCNT_W    = $clog2(NUM_BEATS + 1);

  localparam logic [COEFF_W-1:0] MLDSA_Q = COEFF_W'(8380417);
  localparam logic [COEFF_W:0]   G17     = (COEFF_W+1)'(1 << 17);
  localparam logic [COEFF_W:0]   G19     = (COEFF_W+1)'(1 << 19);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic                         sel_q;
  logic [BUF_W-1:0]             buf_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [WCNT_W-1:0]            wcnt_q;
  logic [BCNT_W-1:0]            bcnt_q;
  logic [NUM_LANES*COEFF_W-1:0] out_q;
  logic                         valid_q;

  logic [WCNT_W-1:0]            words_total;
  logic [CNT_W-1:0]             take_w;
  logic [CNT_W-1:0]             cnt_acc;
  logic [BUF_W-1:0]             data_ext;
  logic [BUF_W-1:0]             comb_buf;
  logic                         accept;
  logic                         extract;
  logic                         beat_hs;
  logic                         last_hs;
  logic [NUM_LANES*COEFF_W-1:0] lane_val;

  // Borrow selects the mod-q wrap; the add is done mod 2^COEFF_W on purpose.
  function automatic logic [COEFF_W-1:0] map_field(input logic [19:0] a, input logic sel);
    logic [COEFF_W:0] diff;
    diff = (sel ? G19 : G17) - {{(COEFF_W-19){1'b0}}, a};
    if (diff[COEFF_W]) return diff[COEFF_W-1:0] + MLDSA_Q;
    else               return diff[COEFF_W-1:0];
  endfunction

  // Datapath view of the incoming word and the bits available this cycle.
  always_comb begin
    words_total = sel_q ? WCNT_W'(WORDS20) : WCNT_W'(WORDS18);
    take_w      = sel_q ? CNT_W'(TAKE20)   : CNT_W'(TAKE18);
    accept      = data_valid_i & data_ready_o;
    data_ext    = {{(BUF_W-IN_W){1'b0}}, data_i};
    cnt_acc     = cnt_q + (accept ? CNT_W'(IN_W) : '0);
    comb_buf    = accept ? (buf_q | (data_ext << cnt_q)) : buf_q;
    beat_hs     = valid_q & coeff_ready_i;
    last_hs     = beat_hs & (bcnt_q == BCNT_W'(NUM_BEATS - 1));
    extract     = (state_q == S_RUN) & (cnt_acc >= take_w) & (~valid_q | coeff_ready_i);
  end

  // Map the lowest beat of the merged buffer into lane coefficients.
  always_comb begin
    lane_val = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (sel_q) lane_val[k*COEFF_W +: COEFF_W] = map_field(comb_buf[k*20 +: 20], 1'b1);
      else       lane_val[k*COEFF_W +: COEFF_W] = map_field({2'b00, comb_buf[k*18 +: 18]}, 1'b0);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)       state_q <= S_IDLE;
    else if (zeroize) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (last_hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    data_ready_o = (state_q == S_RUN) & (wcnt_q < words_total) &
                   (cnt_q <= CNT_W'(BUF_W - IN_W));
    done_o       = (state_q == S_DONE);
  end

  // Bit buffer, counters and output register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sel_q   <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (zeroize) begin
      sel_q   <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        sel_q  <= gamma1_sel_i;
        buf_q  <= '0;
        cnt_q  <= '0;
        wcnt_q <= '0;
        bcnt_q <= '0;
      end else if (state_q == S_RUN) begin
        buf_q <= extract ? (comb_buf >> take_w) : comb_buf;
        cnt_q <= extract ? (cnt_acc - take_w) : cnt_acc;
        if (accept)  wcnt_q <= wcnt_q + 1'b1;
        if (beat_hs) bcnt_q <= bcnt_q + 1'b1;
      end
      if (extract) begin
        out_q   <= lane_val;
        valid_q <= 1'b1;
      end else if (beat_hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign coeff_valid_o = valid_q;
  assign coeff_o       = out_q;

endmodule

// File: tb/tb_exp_mask_unpack.sv
// Bench for exp_mask_unpack: random and directed polynomials checked against
// a coefficient-level model of ExpandMask.
module tb_exp_mask_unpack;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        zeroize;
  logic        start_i;
  logic        gamma1_sel_i;
  logic        data_valid_i;
  logic [63:0] data_i;
  logic        data_ready_o;
  logic        coeff_valid_o;
  logic [91:0] coeff_o;
  logic        coeff_ready_i;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  int          a_vals[256];
  int          exp_vals[256];
  bit          bits[5120];
  logic [63:0] words[80];
  int          dir_a[4];
  logic [91:0] first_beat;
  int          done_cnt;
  int          words_acc;

  exp_mask_unpack dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .zeroize      (zeroize),
    .start_i      (start_i),
    .gamma1_sel_i (gamma1_sel_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .data_ready_o (data_ready_o),
    .coeff_valid_o(coeff_valid_o),
    .coeff_o      (coeff_o),
    .coeff_ready_i(coeff_ready_i),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  // pat: 0 = all-zero fields, 1 = random, 2 = dir_a in the first beat then random.
  // abort_kind: 1 = zeroize, 2 = rst_b, applied once abort_beat beats are taken.
  task automatic run_poly(input bit sel, input int pat, input int rdy_pct, input int vld_pct,
                          input bit noise, input int abort_beat, input int abort_kind);
    int s, bb, nw, g, acc, hs, cyc, held;
    bit in_hs, out_hs, stall, hold, finished;
    logic [91:0] prev_o;
    logic [22:0] got;
    s  = sel ? 20 : 18;
    bb = 4 * s;
    nw = 256 * s / 64;
    g  = sel ? 524288 : 131072;
    for (int i = 0; i < 256; i++) begin
      if (pat == 0)                a_vals[i] = 0;
      else if (pat == 2 && i < 4)  a_vals[i] = dir_a[i];
      else                         a_vals[i] = int'($urandom_range(0, (1 << s) - 1));
      exp_vals[i] = g - a_vals[i];
      if (exp_vals[i] < 0) exp_vals[i] += 8380417;
      for (int b = 0; b < s; b++) bits[i*s + b] = a_vals[i][b];
    end
    for (int w = 0; w < nw; w++)
      for (int j = 0; j < 64; j++) words[w][j] = bits[w*64 + j];

    acc = 0; hs = 0; done_cnt = 0; first_beat = '0;
    in_hs = 0; finished = 0; cyc = 0; stall = 0; prev_o = '0;
    gamma1_sel_i = sel; start_i = 1'b1; data_valid_i = 1'b0; coeff_ready_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;

    while (!finished && cyc < 4000) begin
      cyc++;
      hold = data_valid_i && !in_hs;
      if (!hold) data_valid_i = (acc < nw) && (int'($urandom_range(0, 99)) < vld_pct);
      data_i        = data_valid_i ? words[acc] : {$urandom, $urandom};
      coeff_ready_i = int'($urandom_range(0, 99)) < rdy_pct;
      if (noise) begin
        start_i      = (hs < 64) && ($urandom_range(0, 7) == 0);
        gamma1_sel_i = $urandom_range(0, 1) == 1;
      end
      in_hs  = data_valid_i && data_ready_o;
      out_hs = coeff_valid_o && coeff_ready_i;
      if (out_hs) begin
        if (hs == 0) first_beat = coeff_o;
        for (int k = 0; k < 4; k++) begin
          got = coeff_o[k*23 +: 23];
          checks++;
          if (got !== 23'(exp_vals[hs*4 + k])) begin
            errors++;
            $display("FAIL lane beat%0d lane%0d got %0d exp %0d", hs, k, got, exp_vals[hs*4 + k]);
          end
        end
      end
      stall  = coeff_valid_o && !coeff_ready_i;
      prev_o = coeff_o;
      @(posedge clk); #1;
      start_i = 1'b0;

      if (in_hs) begin
        acc++;
        if ((acc - 1) * 64 < bb && acc * 64 >= bb) begin
          checks++;
          if (coeff_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL first_latency got valid=%b exp 1", coeff_valid_o);
          end
        end
      end
      if (out_hs) hs++;
      if (stall) begin
        checks++;
        if (coeff_valid_o !== 1'b1 || coeff_o !== prev_o) begin
          errors++;
          $display("FAIL stall_stable got valid=%b data=%h exp valid=1 data=%h", coeff_valid_o, coeff_o, prev_o);
        end
      end
      held = acc * 64 - bb * (hs + int'(coeff_valid_o));
      if (data_ready_o === 1'b1) begin
        checks++;
        if (held > 96 || acc >= nw) begin
          errors++;
          $display("FAIL ready_capacity got held=%0d words=%0d exp held<=96 words<%0d", held, acc, nw);
        end
      end
      if (done_o === 1'b1) done_cnt++;

      if (abort_beat >= 0 && out_hs && hs == abort_beat) begin
        data_valid_i = 1'b0; coeff_ready_i = 1'b0; start_i = 1'b0;
        if (abort_kind == 1) begin
          zeroize = 1'b1;
          @(posedge clk); #1;
          zeroize = 1'b0;
        end else begin
          rst_b = 1'b0;
          @(posedge clk); #1;
          rst_b = 1'b1;
        end
        checks++;
        if (data_ready_o !== 1'b0 || coeff_valid_o !== 1'b0 || coeff_o !== '0 || done_o !== 1'b0) begin
          errors++;
          $display("FAIL abort_clear kind%0d got ready=%b valid=%b coeff=%h done=%b exp all 0",
                   abort_kind, data_ready_o, coeff_valid_o, coeff_o, done_o);
        end
        @(posedge clk); #1;
        checks++;
        if (data_ready_o !== 1'b0 || coeff_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL abort_idle kind%0d got ready=%b valid=%b exp 0 0", abort_kind, data_ready_o, coeff_valid_o);
        end
        finished = 1;
      end else if (out_hs && hs == 64) begin
        checks++;
        if (done_o !== 1'b1) begin
          errors++;
          $display("FAIL done_pulse got %b exp 1", done_o);
        end
        data_valid_i = 1'b0; coeff_ready_i = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;
        if (done_o === 1'b1) done_cnt++;
        checks++;
        if (done_o !== 1'b0 || data_ready_o !== 1'b0 || coeff_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL done_after got done=%b ready=%b valid=%b exp 0 0 0", done_o, data_ready_o, coeff_valid_o);
        end
        checks++;
        if (acc !== nw) begin
          errors++;
          $display("FAIL word_count got %0d exp %0d", acc, nw);
        end
        finished = 1;
      end else begin
        checks++;
        if (done_o !== 1'b0) begin
          errors++;
          $display("FAIL done_early got 1 exp 0 at beat %0d", hs);
        end
      end
    end
    if (!finished) begin
      errors++;
      $display("FAIL timeout got beats=%0d words=%0d exp beats=64", hs, acc);
    end
    words_acc = acc;
    data_valid_i = 1'b0; coeff_ready_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (data_ready_o !== 1'b0 || coeff_valid_o !== 1'b0 || coeff_o !== '0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b valid=%b coeff=%h done=%b exp all 0",
               data_ready_o, coeff_valid_o, coeff_o, done_o);
    end
    rst_b = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (data_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got ready=%b exp 0", data_ready_o);
    end
  endtask

  task automatic test_zero_20();
    run_poly(1'b1, 0, 100, 100, 1'b0, -1, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (first_beat[k*23 +: 23] !== 23'd524288) begin
        errors++;
        $display("FAIL zero20_lane%0d got %0d exp 524288", k, first_beat[k*23 +: 23]);
      end
    end
  endtask

  task automatic test_fields_20();
    logic [22:0] req [4];
    dir_a[0] = 1 << 19; dir_a[1] = (1 << 20) - 1; dir_a[2] = 1; dir_a[3] = 0;
    req[0] = 23'd0; req[1] = 23'd7856130; req[2] = 23'd524287; req[3] = 23'd524288;
    run_poly(1'b1, 2, 100, 100, 1'b0, -1, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (first_beat[k*23 +: 23] !== req[k]) begin
        errors++;
        $display("FAIL fields20_lane%0d got %0d exp %0d", k, first_beat[k*23 +: 23], req[k]);
      end
    end
  endtask

  task automatic test_fields_18();
    logic [22:0] req [4];
    dir_a[0] = (1 << 18) - 1; dir_a[1] = 1 << 17; dir_a[2] = 0; dir_a[3] = 5;
    req[0] = 23'd8249346; req[1] = 23'd0; req[2] = 23'd131072; req[3] = 23'd131067;
    run_poly(1'b0, 2, 80, 90, 1'b0, -1, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (first_beat[k*23 +: 23] !== req[k]) begin
        errors++;
        $display("FAIL fields18_lane%0d got %0d exp %0d", k, first_beat[k*23 +: 23], req[k]);
      end
    end
    checks++;
    if (words_acc !== 72 || done_cnt !== 1) begin
      errors++;
      $display("FAIL fields18_totals got words=%0d done=%0d exp 72 1", words_acc, done_cnt);
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 4; m++) begin
      run_poly(m[0], 1, 30 + 20 * m, 40 + 15 * m, 1'b0, -1, 0);
      checks++;
      if (done_cnt !== 1) begin
        errors++;
        $display("FAIL random_done got %0d exp 1", done_cnt);
      end
    end
  endtask

  task automatic test_abort();
    run_poly(1'b1, 1, 70, 80, 1'b0, 30, 1);
    run_poly(1'b1, 1, 70, 80, 1'b0, -1, 0);
    run_poly(1'b0, 1, 70, 80, 1'b0, 30, 2);
    run_poly(1'b0, 1, 70, 80, 1'b0, -1, 0);
  endtask

  task automatic test_noise();
    run_poly(1'b1, 1, 60, 70, 1'b1, -1, 0);
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL noise20_done got %0d exp 1", done_cnt);
    end
    run_poly(1'b0, 1, 60, 70, 1'b1, -1, 0);
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL noise18_done got %0d exp 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    run_poly(1'b0, 1, 100, 100, 1'b0, -1, 0);
    run_poly(1'b1, 1, 100, 100, 1'b0, -1, 0);
  endtask

  initial begin
    rst_b = 1'b0; zeroize = 1'b0; start_i = 1'b0; gamma1_sel_i = 1'b0;
    data_valid_i = 1'b0; data_i = '0; coeff_ready_i = 1'b0;
    test_reset();
    test_zero_20();
    test_fields_20();
    test_fields_18();
    test_random();
    test_abort();
    test_noise();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
